// File: rtl/output_sample_arb_pkg.sv
// Shared types and width helpers for the output_sample round-robin arbiter.
// Imported by the top level and by the rr_pick selector.
package output_sample_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int DEF_NREQ = 4;
    localparam int DEF_LAT  = 2;

    function automatic int id_w(input int nreq);
        return (nreq > 1) ? $clog2(nreq) : 1;
    endfunction

    // The countdown starts at LAT-1; LAT=1 still needs a 1-bit counter.
    function automatic int cnt_w(input int lat);
        return (lat > 1) ? $clog2(lat) : 1;
    endfunction

endpackage

// File: rtl/output_sample_arb_rr_pick.sv
// Combinational round-robin selector.
// Returns the first set request at or above ptr, wrapping modulo NREQ.
module rr_pick
    import output_sample_arb_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int IDW  = id_w(DEF_NREQ)
) (
    input  logic [NREQ-1:0] req_valid,
    input  logic [IDW-1:0]  ptr,
    output logic            any,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  g
);

    int idx;

    always_comb begin
        any = 1'b0;
        gnt = '0;
        g   = '0;
        idx = 0;
        for (int i = 0; i < NREQ; i++) begin
            idx = (int'(ptr) + i) % NREQ;
            if (!any && req_valid[idx]) begin
                any = 1'b1;
                g   = IDW'(idx);
            end
        end
        if (any) begin
            gnt[g] = 1'b1;
        end
    end

endmodule

// File: rtl/output_sample_arb.sv
// Round-robin arbiter/sequencer sharing one output_sample datapath between
// NREQ requesters: grant, wait LAT cycles, capture, return with requester ID.
module output_sample_arb
    import output_sample_arb_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    parameter  int NREQ  = DEF_NREQ,
    parameter  int LAT   = DEF_LAT,
    localparam int IDW   = id_w(NREQ)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_data_1,
    input  logic [NREQ*DEPTH-1:0] req_data_2,
    input  logic [NREQ*16-1:0]    req_data_3,
    output logic [WIDTH-1:0]      dp_input_1,
    output logic [DEPTH-1:0]      dp_input_2,
    output logic [15:0]           dp_input_3,
    input  logic [15:0]           dp_out_1,
    input  logic [WIDTH-1:0]      dp_out_2,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [15:0]           rsp_out_1,
    output logic [WIDTH-1:0]      rsp_out_2,
    output logic                  busy
);

    localparam int              CW       = cnt_w(LAT);
    localparam logic [CW-1:0]   CNT_INIT = CW'(LAT - 1);
    localparam logic [IDW-1:0]  LAST_ID  = IDW'(NREQ - 1);

    state_t            state_q;
    logic [IDW-1:0]    ptr_q;
    logic [IDW-1:0]    ptr_d;
    logic [CW-1:0]     cnt_q;
    logic              rsp_valid_q;
    logic [IDW-1:0]    rsp_id_q;
    logic [15:0]       rsp_out_1_q;
    logic [WIDTH-1:0]  rsp_out_2_q;
    logic [WIDTH-1:0]  dp_input_1_q;
    logic [DEPTH-1:0]  dp_input_2_q;
    logic [15:0]       dp_input_3_q;

    logic              any;
    logic [NREQ-1:0]   gnt;
    logic [IDW-1:0]    g;

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .req_valid (req_valid),
        .ptr       (ptr_q),
        .any       (any),
        .gnt       (gnt),
        .g         (g)
    );

    // Explicit wrap so non-power-of-two NREQ never points past the last requester.
    assign ptr_d = (g == LAST_ID) ? '0 : g + 1'b1;

    // Accept is combinational in IDLE; reset masks it so no handshake is seen.
    assign req_ready = (state_q == IDLE && !RST) ? gnt : '0;
    assign busy      = (state_q != IDLE);

    assign dp_input_1 = dp_input_1_q;
    assign dp_input_2 = dp_input_2_q;
    assign dp_input_3 = dp_input_3_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_out_1  = rsp_out_1_q;
    assign rsp_out_2  = rsp_out_2_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            cnt_q        <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_out_1_q  <= '0;
            rsp_out_2_q  <= '0;
            dp_input_1_q <= '0;
            dp_input_2_q <= '0;
            dp_input_3_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any) begin
                        dp_input_1_q <= req_data_1[int'(g)*WIDTH +: WIDTH];
                        dp_input_2_q <= req_data_2[int'(g)*DEPTH +: DEPTH];
                        dp_input_3_q <= req_data_3[int'(g)*16 +: 16];
                        rsp_id_q     <= g;
                        ptr_q        <= ptr_d;
                        cnt_q        <= CNT_INIT;
                        state_q      <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_q == '0) begin
                        rsp_out_1_q <= dp_out_1;
                        rsp_out_2_q <= dp_out_2;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_output_sample_arb.sv
// Directed bench for output_sample_arb (NREQ=4, LAT=2) with a driven datapath stub.
module tb_output_sample_arb;

    logic        CLK = 1'b0;
    logic        RST;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [31:0] req_data_1;
    logic [15:0] req_data_2;
    logic [63:0] req_data_3;
    logic [7:0]  dp_input_1;
    logic [3:0]  dp_input_2;
    logic [15:0] dp_input_3;
    logic [15:0] dp_out_1;
    logic [7:0]  dp_out_2;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [15:0] rsp_out_1;
    logic [7:0]  rsp_out_2;
    logic        busy;

    int n_chk = 0;
    int n_err = 0;

    output_sample_arb #(
        .WIDTH (8),
        .DEPTH (4),
        .NREQ  (4),
        .LAT   (2)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_data_1 (req_data_1),
        .req_data_2 (req_data_2),
        .req_data_3 (req_data_3),
        .dp_input_1 (dp_input_1),
        .dp_input_2 (dp_input_2),
        .dp_input_3 (dp_input_3),
        .dp_out_1   (dp_out_1),
        .dp_out_2   (dp_out_2),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_out_1  (rsp_out_1),
        .rsp_out_2  (rsp_out_2),
        .busy       (busy)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge and settle away from it.
    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".req_ready"}, 32'(req_ready), 32'h0);
        chk({tag, ".dp_in1"},    32'(dp_input_1), 32'h0);
        chk({tag, ".dp_in2"},    32'(dp_input_2), 32'h0);
        chk({tag, ".dp_in3"},    32'(dp_input_3), 32'h0);
        chk({tag, ".rsp_valid"}, 32'(rsp_valid), 32'h0);
        chk({tag, ".rsp_id"},    32'(rsp_id), 32'h0);
        chk({tag, ".rsp_out1"},  32'(rsp_out_1), 32'h0);
        chk({tag, ".rsp_out2"},  32'(rsp_out_2), 32'h0);
        chk({tag, ".busy"},      32'(busy), 32'h0);
    endtask

    // One full transaction with rsp_ready high: 4 cycles from grant to next IDLE.
    task automatic txn(input string tag, input logic [3:0] vld, input int exp_g,
                       input logic [15:0] o1, input logic [7:0] o2);
        logic [7:0] exp_d1;
        exp_d1 = 8'(8'h11 * (exp_g + 1));
        req_valid = vld;
        dp_out_1  = o1;
        dp_out_2  = o2;
        #1;
        chk({tag, ".grant"}, 32'(req_ready), 32'(4'b0001 << exp_g));
        tick();
        chk({tag, ".dp_in1"}, 32'(dp_input_1), 32'(exp_d1));
        chk({tag, ".dp_in3"}, 32'(dp_input_3), 32'(16'hC000 + 16'(exp_g)));
        chk({tag, ".wait_ready"}, 32'(req_ready), 32'h0);
        tick();
        chk({tag, ".wait_valid"}, 32'(rsp_valid), 32'h0);
        tick();
        chk({tag, ".rsp_valid"}, 32'(rsp_valid), 32'h1);
        chk({tag, ".rsp_id"}, 32'(rsp_id), 32'(exp_g));
        chk({tag, ".rsp_out1"}, 32'(rsp_out_1), 32'(o1));
        tick();
        chk({tag, ".done"}, 32'(rsp_valid), 32'h0);
    endtask

    initial begin
        RST        = 1'b1;
        req_valid  = 4'b1011;
        req_data_1 = {8'h44, 8'h33, 8'h22, 8'h11};
        req_data_2 = {4'h4, 4'h3, 4'h2, 4'h1};
        req_data_3 = {16'hC003, 16'hC002, 16'hC001, 16'hC000};
        dp_out_1   = 16'h0;
        dp_out_2   = 8'h0;
        rsp_ready  = 1'b0;

        // Reset held two cycles with requests present.
        tick();
        chk_all_zero("rst1");
        req_valid = 4'b0110;
        tick();
        chk_all_zero("rst2");
        RST       = 1'b0;
        req_valid = 4'b0000;
        #1;
        chk_all_zero("idle0");

        // Single request from requester 0.
        req_data_1[7:0]  = 8'hA5;
        req_data_2[3:0]  = 4'h3;
        req_data_3[15:0] = 16'h1234;
        dp_out_1  = 16'hBEEF;
        dp_out_2  = 8'h5A;
        req_valid = 4'b0001;
        #1;
        chk("single.ready", 32'(req_ready), 32'h1);
        chk("single.busy_idle", 32'(busy), 32'h0);
        tick();
        req_valid = 4'b0000;
        chk("single.dp_in1", 32'(dp_input_1), 32'hA5);
        chk("single.dp_in2", 32'(dp_input_2), 32'h3);
        chk("single.dp_in3", 32'(dp_input_3), 32'h1234);
        chk("single.busy", 32'(busy), 32'h1);
        tick();
        chk("single.early", 32'(rsp_valid), 32'h0);
        tick();
        chk("single.rsp_valid", 32'(rsp_valid), 32'h1);
        chk("single.rsp_id", 32'(rsp_id), 32'h0);
        chk("single.rsp_out1", 32'(rsp_out_1), 32'hBEEF);
        chk("single.rsp_out2", 32'(rsp_out_2), 32'h5A);
        rsp_ready = 1'b1;
        tick();
        chk("single.rsp_done", 32'(rsp_valid), 32'h0);
        chk("single.idle", 32'(busy), 32'h0);
        chk("single.hold", 32'(dp_input_1), 32'hA5);

        // Fresh pointer, then all four requesters hold valid.
        req_data_1[7:0]  = 8'h11;
        req_data_3[15:0] = 16'hC000;
        RST = 1'b1;
        tick();
        RST = 1'b0;
        for (int k = 0; k < 5; k++) begin
            txn($sformatf("fair%0d", k), 4'b1111, k % 4, 16'(16'h1000 + k), 8'(k));
        end

        // ptr is now 1: grant 1, then 4'b0011 searches 2,3,0 and grants 0.
        txn("wrap_a", 4'b0010, 1, 16'h2001, 8'h21);
        txn("wrap_b", 4'b0011, 0, 16'h2002, 8'h22);
        txn("wrap_c", 4'b0011, 1, 16'h2003, 8'h23);

        // Backpressure on requester 2 while the stub keeps changing.
        rsp_ready = 1'b0;
        req_valid = 4'b0100;
        dp_out_1  = 16'hAAAA;
        dp_out_2  = 8'h77;
        #1;
        chk("bp.grant", 32'(req_ready), 32'h4);
        tick();
        req_valid = 4'b1111;
        tick();
        tick();
        chk("bp.rsp_valid", 32'(rsp_valid), 32'h1);
        for (int k = 0; k < 5; k++) begin
            dp_out_1 = 16'(16'h5550 + k);
            dp_out_2 = 8'(8'h90 + k);
            tick();
            chk($sformatf("bp%0d.valid", k), 32'(rsp_valid), 32'h1);
            chk($sformatf("bp%0d.id", k), 32'(rsp_id), 32'h2);
            chk($sformatf("bp%0d.out1", k), 32'(rsp_out_1), 32'hAAAA);
            chk($sformatf("bp%0d.out2", k), 32'(rsp_out_2), 32'h77);
            chk($sformatf("bp%0d.ready", k), 32'(req_ready), 32'h0);
        end
        rsp_ready = 1'b1;
        tick();
        chk("bp.done", 32'(rsp_valid), 32'h0);
        chk("bp.next_grant", 32'(req_ready), 32'h8);
        req_valid = 4'b0000;

        // Reset one cycle after a grant abandons the transaction.
        req_valid = 4'b1000;
        #1;
        chk("rstw.grant", 32'(req_ready), 32'h8);
        tick();
        req_valid = 4'b0000;
        RST = 1'b1;
        chk("rstw.busy_pre", 32'(busy), 32'h1);
        tick();
        RST = 1'b0;
        chk("rstw.busy", 32'(busy), 32'h0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("rstw%0d.no_rsp", k), 32'(rsp_valid), 32'h0);
        end
        req_valid = 4'b1111;
        #1;
        chk("rstw.ptr0", 32'(req_ready), 32'h1);
        tick();
        req_valid = 4'b0000;
        chk("rstw.dp_in1", 32'(dp_input_1), 32'h11);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
